// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction fetch responder with boot-time load port
module imem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        ld_valid,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        busy
);
    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_STATES);
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_WAIT  = 2'd1;
    localparam logic [1:0]  S_RESP  = 2'd2;

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rd_off, ld_off;
    logic        rd_ok, ld_ok, ld_we, accept, load_rsp;

    always_comb begin
        req_ready  = !ld_valid && (state_q == S_IDLE || (state_q == S_RESP && rsp_ready));
        accept     = req_valid && req_ready;
        // read data is captured on whichever edge enters RESP
        load_rsp   = (accept && WAIT_STATES == 0) || (state_q == S_WAIT && cnt_q == 4'd1);
        rd_off     = (accept ? req_addr : addr_q) - BASE_ADDR;
        rd_ok      = rd_off[1:0] == 2'b00 && {2'b00, rd_off[31:2]} < DEPTH_L;
        ld_off     = ld_addr - BASE_ADDR;
        ld_ok      = ld_off[1:0] == 2'b00 && {2'b00, ld_off[31:2]} < DEPTH_L;
        ld_we      = ld_valid && state_q == S_IDLE && ld_ok;
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if (accept) begin
            addr_d  = req_addr;
            cnt_d   = WAIT_L;
            state_d = WAIT_STATES == 0 ? S_RESP : S_WAIT;
            rsp_err_d = 1'b0;
        end else if (state_q == S_RESP && rsp_ready) begin
            state_d   = S_IDLE;
            rsp_err_d = 1'b0;
        end else if (state_q == S_WAIT) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd1 ? S_RESP : S_WAIT;
        end
        if (load_rsp) begin
            rsp_data_d = rd_ok ? mem_q[rd_off[AW+1:2]] : 32'h0000_0013;
            rsp_err_d  = !rd_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ld_we) mem_q[ld_off[AW+1:2]] <= ld_data;
    end

    assign rsp_valid = state_q == S_RESP;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = state_q != S_IDLE;
endmodule
